// File: rtl/sal_fifo_ser.sv
// sal_fifo_ser
//   Drain stage for a first-word-fall-through FIFO. Each IN_WIDTH word that
//   is popped is emitted as 2^RATIO_LG2 beats of OUT_WIDTH bits on a
//   valid/ready interface. last_o marks the final beat of each word. When the
//   FIFO is non-empty, the next word is popped on the last-beat transfer, so
//   there is no bubble between consecutive words.
//
//   Optional feature: define SAL_FIFO_SER_MSB_FIRST_EN to emit the
//   most-significant slice first. The default build emits the
//   least-significant slice first.
//
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_rden_o   pop request to the FIFO (combinational)
//   fifo_rdata_i  FIFO head word, valid while fifo_empty_i=0
//   valid_o       beat valid
//   ready_i       downstream accepts the beat
//   data_o        current beat
//   last_o        current beat is the final beat of its word
//   idle_o        no word held
module sal_fifo_ser #(
  parameter int IN_WIDTH  = 128,
  parameter int RATIO_LG2 = 2,
  parameter int OUT_WIDTH = IN_WIDTH >> RATIO_LG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rden_o,
  input  logic [IN_WIDTH-1:0]  fifo_rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o,
  output logic                 idle_o
);

  localparam int NBEATS = 1 << RATIO_LG2;
  // The counter keeps at least one bit so that RATIO_LG2=0 still elaborates.
  // In that configuration it stays at 0.
  localparam int CW = (RATIO_LG2 > 0) ? RATIO_LG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q,  hold_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [CW-1:0]         slice_sel;
  logic                  xfer;
  int                    shamt;

  // All beat outputs come from registered state only. ready_i reaches only
  // the pop request and the next-state logic.
  assign valid_o = (state_q == BUSY);
  assign idle_o  = (state_q == IDLE);
  assign last_o  = valid_o && (cnt_q == CNT_LAST);
  assign xfer    = valid_o && ready_i;

  // Pop when empty-handed, or when the last beat of the current word leaves
  // this cycle. rst_n gating keeps the FIFO safe while the stage is reset.
  assign fifo_rden_o = rst_n && !fifo_empty_i && (idle_o || (xfer && last_o));

`ifdef SAL_FIFO_SER_MSB_FIRST_EN
  assign slice_sel = CNT_LAST - cnt_q;
`else
  assign slice_sel = cnt_q;
`endif

  always_comb begin
    shamt  = int'(slice_sel) * OUT_WIDTH;
    data_o = OUT_WIDTH'(hold_q >> shamt);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fifo_rden_o) begin
          hold_d  = fifo_rdata_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (!last_o) begin
            cnt_d = cnt_q + CW'(1);
          end else if (fifo_rden_o) begin
            // Chain straight into the next word without leaving BUSY.
            hold_d = fifo_rdata_i;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sal_fifo_ser.sv
module tb_sal_fifo_ser;

  logic        clk;
  logic        rst_n;
  logic        ready;

  // DUT 0: 32-bit words, four 8-bit beats
  logic        empty0, rden0, valid0, last0, idle0;
  logic [31:0] rdata0;
  logic [7:0]  data0;
  // DUT 1: 32-bit words, 1:1 pass-through
  logic        empty1, rden1, valid1, last1, idle1;
  logic [31:0] rdata1;
  logic [31:0] data1;

  // FWFT FIFO models
  logic [31:0] mem0 [0:15];
  logic [31:0] mem1 [0:15];
  int          wr0, rd0, wr1, rd1;
  int          uflow;

  int          checks;
  int          errors;

  sal_fifo_ser #(.IN_WIDTH(32), .RATIO_LG2(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty_i(empty0), .fifo_rden_o(rden0), .fifo_rdata_i(rdata0),
    .valid_o(valid0), .ready_i(ready), .data_o(data0),
    .last_o(last0), .idle_o(idle0)
  );

  sal_fifo_ser #(.IN_WIDTH(32), .RATIO_LG2(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty_i(empty1), .fifo_rden_o(rden1), .fifo_rdata_i(rdata1),
    .valid_o(valid1), .ready_i(ready), .data_o(data1),
    .last_o(last1), .idle_o(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);
  assign rdata0 = mem0[rd0[3:0]];
  assign rdata1 = mem1[rd1[3:0]];

  always @(posedge clk) begin
    if (rden0 && empty0) uflow <= uflow + 1;
    if (rden1 && empty1) uflow <= uflow + 1;
    if (rden0 && !empty0) rd0 <= rd0 + 1;
    if (rden1 && !empty1) rd1 <= rd1 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wr0[3:0]] = w;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [31:0] w);
    mem1[wr1[3:0]] = w;
    wr1 = wr1 + 1;
  endtask

  // Move to the middle of the next cycle. Stimulus changes here, then #1
  // lets the combinational outputs settle before sampling.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Byte b (beat index b) of word w, in emission order.
  function automatic logic [7:0] beat(input logic [31:0] w, input int b);
`ifdef SAL_FIFO_SER_MSB_FIRST_EN
    return 8'(w >> (8 * (3 - b)));
`else
    return 8'(w >> (8 * b));
`endif
  endfunction

  // Checks one beat presented with ready=1.
  task automatic expect_beat(input string tag, input logic [31:0] w, input int b,
                             input logic exp_rden);
    next_cycle();
    #1;
    check({tag, "_valid"}, 64'(valid0), 64'd1);
    check({tag, "_data"},  64'(data0),  64'(beat(w, b)));
    check({tag, "_last"},  64'(last0),  64'(b == 3));
    check({tag, "_rden"},  64'(rden0),  64'(exp_rden));
  endtask

  initial begin
    checks = 0; errors = 0;
    wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; uflow = 0;
    rst_n = 1'b0;
    ready = 1'b0;

    // Reset, with a word already waiting in the FIFO
    next_cycle();
    next_cycle();
    push0(32'hDDCCBBAA);
    #1;
    check("rst_valid", 64'(valid0), 64'd0);
    check("rst_idle",  64'(idle0),  64'd1);
    check("rst_data",  64'(data0),  64'd0);
    check("rst_last",  64'(last0),  64'd0);
    check("rst_rden",  64'(rden0),  64'd0);

    // Single word
    next_cycle();
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    check("t1_rden0", 64'(rden0),  64'd1);
    check("t1_idle0", 64'(idle0),  64'd1);
    for (int b = 0; b < 4; b++) expect_beat("t1", 32'hDDCCBBAA, b, 1'b0);
    next_cycle();
    #1;
    check("t1_idle_end",  64'(idle0),  64'd1);
    check("t1_valid_end", 64'(valid0), 64'd0);

    // Back-to-back words
    next_cycle();
    push0(32'h44332211);
    push0(32'h88776655);
    #1;
    check("t2_rden0", 64'(rden0), 64'd1);
    for (int b = 0; b < 4; b++) expect_beat("t2a", 32'h44332211, b, b == 3);
    for (int b = 0; b < 4; b++) expect_beat("t2b", 32'h88776655, b, 1'b0);
    next_cycle();
    #1;
    check("t2_idle_end", 64'(idle0), 64'd1);

    // Backpressure on BB, with a second word arriving during the stall
    next_cycle();
    push0(32'hDDCCBBAA);
    #1;
    check("t3_rden0", 64'(rden0), 64'd1);
    expect_beat("t3", 32'hDDCCBBAA, 0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      ready = 1'b0;
      if (s == 0) push0(32'h44332211);
      #1;
      check("t3_stall_valid", 64'(valid0), 64'd1);
      check("t3_stall_data",  64'(data0),  64'(beat(32'hDDCCBBAA, 1)));
      check("t3_stall_last",  64'(last0),  64'd0);
      check("t3_stall_rden",  64'(rden0),  64'd0);
    end
    next_cycle();
    ready = 1'b1;
    #1;
    check("t3_resume_data", 64'(data0), 64'(beat(32'hDDCCBBAA, 1)));
    expect_beat("t3", 32'hDDCCBBAA, 2, 1'b0);
    expect_beat("t3", 32'hDDCCBBAA, 3, 1'b1);
    for (int b = 0; b < 4; b++) expect_beat("t3n", 32'h44332211, b, 1'b0);

    // Empty FIFO with ready toggling
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      ready = c[0];
      #1;
      check("t4_rden",  64'(rden0),  64'd0);
      check("t4_valid", 64'(valid0), 64'd0);
    end

    // Reset in the middle of a word
    next_cycle();
    ready = 1'b1;
    push0(32'hDDCCBBAA);
    #1;
    check("t5_rden0", 64'(rden0), 64'd1);
    expect_beat("t5", 32'hDDCCBBAA, 0, 1'b0);
    expect_beat("t5", 32'hDDCCBBAA, 1, 1'b0);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("t5_valid", 64'(valid0), 64'd0);
    check("t5_idle",  64'(idle0),  64'd1);
    check("t5_data",  64'(data0),  64'd0);
    check("t5_rden_empty", 64'(rden0), 64'd0);
    next_cycle();
    push0(32'h44332211);
    #1;
    check("t5_rden_next", 64'(rden0), 64'd1);
    for (int b = 0; b < 4; b++) expect_beat("t5n", 32'h44332211, b, 1'b0);

    // 1:1 pass-through
    next_cycle();
    push1(32'h1);
    push1(32'h2);
    push1(32'h3);
    #1;
    check("t6_rden0", 64'(rden1), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      #1;
      check("t6_valid", 64'(valid1), 64'd1);
      check("t6_data",  64'(data1),  64'(k));
      check("t6_last",  64'(last1),  64'd1);
      check("t6_rden",  64'(rden1),  64'(k < 3));
    end
    next_cycle();
    #1;
    check("t6_idle_end", 64'(idle1), 64'd1);

    check("underflow", 64'(uflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
